// File: rtl/vx_tcu_idp_pipe.sv
// Integer dot-product pipeline: D = sum(A[i][e]*B[i][e]) + C over N packed lanes,
// with optional int32 saturation, overflow flag, tag sideband and valid/ready handshake.
module vx_tcu_idp_pipe #(
  parameter int N       = 4,
  parameter int LATENCY = 3,
  parameter int TAGW    = 8,
  parameter int XLEN    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [2:0]        fmt_s,
  input  logic              sat,
  input  logic [N*XLEN-1:0] a_row,
  input  logic [N*XLEN-1:0] b_col,
  input  logic [XLEN-1:0]   c_val,
  input  logic [TAGW-1:0]   tag_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [XLEN-1:0]   d_val,
  output logic [TAGW-1:0]   tag_out,
  output logic              ovf_out
);

  localparam int NP = N * 8;
  localparam int PW = 18;
  localparam int SW = 48;
  localparam int ND = (LATENCY < 3) ? 1 : LATENCY - 2;

  generate
    if (LATENCY < 3) begin : g_bad_latency
      $error("vx_tcu_idp_pipe: LATENCY must be at least 3");
    end
    if (XLEN < 32) begin : g_bad_xlen
      $error("vx_tcu_idp_pipe: XLEN must be at least 32");
    end
  endgenerate

  logic stall;
  logic advance;
  assign stall    = valid_out & ~ready_out;
  assign advance  = ~stall;
  assign ready_in = ~stall;

  logic is8, is4, sgn;
  assign is8 = (fmt_s == 3'd4) || (fmt_s == 3'd5);
  assign is4 = (fmt_s == 3'd6) || (fmt_s == 3'd7);
  assign sgn = (fmt_s == 3'd4) || (fmt_s == 3'd6);

  // Each lane yields 8 product slots; 8-bit formats only populate the low 4.
  logic signed [PW-1:0] prod_next [NP];
  logic signed [PW-1:0] prod_reg  [NP];

  genvar gi, ge;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      for (ge = 0; ge < 8; ge++) begin : g_elem
        logic [7:0] a8, b8;
        logic [3:0] a4, b4;
        logic signed [8:0] ax, bx;
        assign a4 = a_row[gi*XLEN + ge*4 +: 4];
        assign b4 = b_col[gi*XLEN + ge*4 +: 4];
        if (ge < 4) begin : g_w8
          assign a8 = a_row[gi*XLEN + ge*8 +: 8];
          assign b8 = b_col[gi*XLEN + ge*8 +: 8];
        end else begin : g_w4_only
          assign a8 = '0;
          assign b8 = '0;
        end
        always_comb begin
          ax = '0;
          bx = '0;
          if (is8) begin
            ax = {sgn & a8[7], a8};
            bx = {sgn & b8[7], b8};
          end else if (is4) begin
            ax = {{5{sgn & a4[3]}}, a4};
            bx = {{5{sgn & b4[3]}}, b4};
          end
        end
        assign prod_next[gi*8 + ge] = PW'(ax) * PW'(bx);
      end
    end
  endgenerate

  logic            v1_reg, sat1_reg;
  logic [31:0]     c1_reg;
  logic [TAGW-1:0] tag1_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg   <= 1'b0;
      sat1_reg <= 1'b0;
      c1_reg   <= '0;
      tag1_reg <= '0;
      for (int k = 0; k < NP; k++) prod_reg[k] <= '0;
    end else if (advance) begin
      v1_reg   <= valid_in;
      sat1_reg <= sat;
      c1_reg   <= c_val[31:0];
      tag1_reg <= tag_in;
      for (int k = 0; k < NP; k++) prod_reg[k] <= prod_next[k];
    end
  end

  logic signed [SW-1:0] sum_next;
  logic signed [SW-1:0] sum_reg;
  logic                 v2_reg, sat2_reg;
  logic [31:0]          c2_reg;
  logic [TAGW-1:0]      tag2_reg;

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < NP; k++)
      sum_next = sum_next + $signed({{(SW-PW){prod_reg[k][PW-1]}}, prod_reg[k]});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2_reg   <= 1'b0;
      sat2_reg <= 1'b0;
      c2_reg   <= '0;
      tag2_reg <= '0;
      sum_reg  <= '0;
    end else if (advance) begin
      v2_reg   <= v1_reg;
      sat2_reg <= sat1_reg;
      c2_reg   <= c1_reg;
      tag2_reg <= tag1_reg;
      sum_reg  <= sum_next;
    end
  end

  // The result fits int32 exactly when bits [SW-1:31] are a pure sign extension.
  logic signed [SW-1:0] s_full;
  logic                 ovf_next;
  logic [31:0]          d_next;

  always_comb begin
    s_full   = sum_reg + $signed({{(SW-32){c2_reg[31]}}, c2_reg});
    ovf_next = !((&s_full[SW-1:31]) || !(|s_full[SW-1:31]));
    d_next   = s_full[31:0];
    if (sat2_reg && ovf_next)
      d_next = s_full[SW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  logic            v_pipe_reg   [ND];
  logic [31:0]     d_pipe_reg   [ND];
  logic            ovf_pipe_reg [ND];
  logic [TAGW-1:0] tag_pipe_reg [ND];

  always_ff @(posedge clk) begin
    if (reset) begin
      v_pipe_reg[0]   <= 1'b0;
      d_pipe_reg[0]   <= '0;
      ovf_pipe_reg[0] <= 1'b0;
      tag_pipe_reg[0] <= '0;
    end else if (advance) begin
      v_pipe_reg[0]   <= v2_reg;
      d_pipe_reg[0]   <= d_next;
      ovf_pipe_reg[0] <= ovf_next;
      tag_pipe_reg[0] <= tag2_reg;
    end
  end

  generate
    for (gi = 1; gi < ND; gi++) begin : g_delay
      always_ff @(posedge clk) begin
        if (reset) begin
          v_pipe_reg[gi]   <= 1'b0;
          d_pipe_reg[gi]   <= '0;
          ovf_pipe_reg[gi] <= 1'b0;
          tag_pipe_reg[gi] <= '0;
        end else if (advance) begin
          v_pipe_reg[gi]   <= v_pipe_reg[gi-1];
          d_pipe_reg[gi]   <= d_pipe_reg[gi-1];
          ovf_pipe_reg[gi] <= ovf_pipe_reg[gi-1];
          tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign valid_out = v_pipe_reg[ND-1];
  assign d_val     = XLEN'($signed(d_pipe_reg[ND-1]));
  assign tag_out   = tag_pipe_reg[ND-1];
  assign ovf_out   = ovf_pipe_reg[ND-1];

endmodule

// File: tb/tb_vx_tcu_idp_pipe.sv
// Scoreboard bench for vx_tcu_idp_pipe (N=8, LATENCY=3): directed vectors,
// backpressure, mid-flight reset and a randomised stream against a golden model.
module tb_vx_tcu_idp_pipe;
  localparam int N    = 8;
  localparam int LAT  = 3;
  localparam int TAGW = 8;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              valid_in;
  logic              ready_in;
  logic [2:0]        fmt_s;
  logic              sat;
  logic [N*XLEN-1:0] a_row;
  logic [N*XLEN-1:0] b_col;
  logic [XLEN-1:0]   c_val;
  logic [TAGW-1:0]   tag_in;
  logic              valid_out;
  logic              ready_out;
  logic [XLEN-1:0]   d_val;
  logic [TAGW-1:0]   tag_out;
  logic              ovf_out;

  vx_tcu_idp_pipe #(.N(N), .LATENCY(LAT), .TAGW(TAGW), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .fmt_s(fmt_s), .sat(sat), .a_row(a_row), .b_col(b_col), .c_val(c_val),
    .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
    .d_val(d_val), .tag_out(tag_out), .ovf_out(ovf_out)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  tag;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;

  // Golden model of the exact dot product with int32 saturation/wrap.
  function automatic void model(input logic [2:0] fmt, input logic s,
                                input logic [255:0] a, input logic [255:0] b,
                                input logic [31:0] c,
                                output logic [31:0] d, output logic o);
    longint acc, av, bv;
    int w, ne;
    logic [255:0] ta, tb;
    acc = longint'($signed(c));
    if (fmt >= 3'd4) begin
      w  = (fmt < 3'd6) ? 8 : 4;
      ne = 32 / w;
      for (int i = 0; i < N; i++) begin
        for (int e = 0; e < ne; e++) begin
          ta = a >> (i*32 + e*w);
          tb = b >> (i*32 + e*w);
          if (w == 8) begin
            av = longint'(ta[7:0]);
            bv = longint'(tb[7:0]);
          end else begin
            av = longint'(ta[3:0]);
            bv = longint'(tb[3:0]);
          end
          if (fmt == 3'd4 || fmt == 3'd6) begin
            if (av >= longint'(1 << (w-1))) av = av - longint'(1 << w);
            if (bv >= longint'(1 << (w-1))) bv = bv - longint'(1 << w);
          end
          acc = acc + av * bv;
        end
      end
    end
    o = (acc > 64'sd2147483647) || (acc < -64'sd2147483648);
    if (s && acc > 64'sd2147483647)       d = 32'h7FFF_FFFF;
    else if (s && acc < -64'sd2147483648) d = 32'h8000_0000;
    else                                  d = acc[31:0];
  endfunction

  // Present one beat (called just after a rising edge) and hold it until accepted.
  task automatic drive(input logic [2:0] fmt, input logic s, input logic [255:0] a,
                       input logic [255:0] b, input logic [31:0] c, input logic [7:0] tag,
                       input bit use_model, input logic [31:0] xd, input logic xo);
    exp_t e;
    logic [31:0] md;
    logic mo;
    bit acc;
    int waitc;
    if (use_model) begin
      model(fmt, s, a, b, c, md, mo);
      e.d = md;
      e.ovf = mo;
    end else begin
      e.d = xd;
      e.ovf = xo;
    end
    e.tag = tag;
    valid_in = 1'b1; fmt_s = fmt; sat = s; a_row = a; b_col = b; c_val = c; tag_in = tag;
    acc = 1'b0;
    waitc = 0;
    while (!acc) begin
      @(negedge clk);
      acc = ready_in && !reset;
      @(posedge clk);
      if (acc) sb.push_back(e);
      #1;
      if (!acc) begin
        waitc++;
        if (waitc > 200) begin
          n_cmp++; n_bad++;
          $display("FAIL accept_timeout: ready_in=%b, required 1", ready_in);
          break;
        end
      end
    end
    valid_in = 1'b0;
  endtask

  // Output monitor: every output transfer is popped and compared in order.
  always @(negedge clk) begin
    if (valid_out === 1'b1 && ready_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got tag %h d %h, required no output", tag_out, d_val);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_out++;
        n_cmp++;
        if (d_val !== e.d) begin
          n_bad++;
          $display("FAIL d_val tag %h: got %h, required %h", e.tag, d_val, e.d);
        end
        n_cmp++;
        if (ovf_out !== e.ovf) begin
          n_bad++;
          $display("FAIL ovf_out tag %h: got %b, required %b", e.tag, ovf_out, e.ovf);
        end
        n_cmp++;
        if (tag_out !== e.tag) begin
          n_bad++;
          $display("FAIL tag_out: got %h, required %h", tag_out, e.tag);
        end
        $display("out tag %h d %h ovf %b", tag_out, d_val, ovf_out);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; ready_out = 1'b1;
    valid_in = 1'b1; fmt_s = 3'd4; sat = 1'b0; c_val = 32'd99; tag_in = 8'hEE;
    a_row = {8{32'h0101_0101}}; b_col = {8{32'h0101_0101}};
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b, required 0", valid_out); end
    n_cmp++; if (d_val !== 32'h0) begin n_bad++; $display("FAIL reset_d_val: got %h, required 0", d_val); end
    n_cmp++; if (tag_out !== 8'h0) begin n_bad++; $display("FAIL reset_tag_out: got %h, required 0", tag_out); end
    n_cmp++; if (ovf_out !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_out: got %b, required 0", ovf_out); end
    reset = 1'b0; valid_in = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL reset_ready_in: got %b, required 1", ready_in); end
    repeat (4) @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_vectors();
    drive(3'd4, 1'b0, 256'h0102_0304_0102_0304, 256'h0101_0101_0101_0101, 32'd5, 8'h3C, 1'b0, 32'd25, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== (k == 2)) begin
        n_bad++;
        $display("FAIL latency_cycle%0d: valid_out=%b, required %b", k + 1, valid_out, (k == 2));
      end
    end
    @(posedge clk); #1;
    drive(3'd5, 1'b1, 256'hFFFF_FFFF, 256'hFFFF_FFFF, 32'h7FFF_FFFF, 8'h01, 1'b0, 32'h7FFF_FFFF, 1'b1);
    drive(3'd5, 1'b0, 256'hFFFF_FFFF, 256'hFFFF_FFFF, 32'h7FFF_FFFF, 8'h02, 1'b0, 32'h8003_F803, 1'b1);
    drive(3'd6, 1'b0, 256'hFFFF_FFFF, 256'h1111_1111, 32'h0, 8'h03, 1'b0, 32'hFFFF_FFF8, 1'b0);
    drive(3'd7, 1'b0, 256'hFFFF_FFFF, 256'h1111_1111, 32'h0, 8'h04, 1'b0, 32'd120, 1'b0);
    drive(3'd1, 1'b0, 256'hFFFF_FFFF, 256'h1111_1111, 32'd7, 8'h05, 1'b0, 32'd7, 1'b0);
    drive(3'd4, 1'b1, {8{32'h8080_8080}}, {8{32'h7F7F_7F7F}}, 32'h8000_0000, 8'h06, 1'b0, 32'h8000_0000, 1'b1);
    drive(3'd4, 1'b0, {8{32'h8080_8080}}, {8{32'h7F7F_7F7F}}, 32'h8000_0000, 8'h07, 1'b0, 32'h7FF8_1000, 1'b1);
    drive(3'd4, 1'b1, 256'h0, {8{32'hFFFF_FFFF}}, 32'h7FFF_FFFF, 8'h08, 1'b0, 32'h7FFF_FFFF, 1'b0);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL vectors_drain: %0d pending, required 0", sb.size()); end
    @(posedge clk); #1;
    $display("test_vectors done");
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_out;
    ready_out = 1'b0;
    fork
      begin
        for (int t = 1; t <= 6; t++)
          drive(3'd4, 1'b0, 256'(t), 256'h3, 32'd1000, 8'(t), 1'b0, 32'(1000 + 3*t), 1'b0);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = (valid_out === 1'b1);
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL bp_valid_timeout: valid_out=%b, required 1", valid_out); end
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          n_cmp++;
          if (ready_in !== 1'b0) begin n_bad++; $display("FAIL bp_ready_in cyc%0d: got %b, required 0", i, ready_in); end
          n_cmp++;
          if (tag_out !== 8'h01 || d_val !== 32'd1003 || valid_out !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold cyc%0d: got v=%b tag=%h d=%0d, required v=1 tag=01 d=1003", i, valid_out, tag_out, d_val);
          end
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    n_cmp++;
    if (n_out - n0 != 6 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL bp_delivered: got %0d results (%0d pending), required 6", n_out - n0, sb.size());
    end
    @(posedge clk); #1;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    int n0;
    n0 = n_out;
    ready_out = 1'b0;
    drive(3'd5, 1'b0, 256'h2, 256'h2, 32'd10, 8'h41, 1'b1, 32'h0, 1'b0);
    drive(3'd5, 1'b0, 256'h3, 256'h3, 32'd10, 8'h42, 1'b1, 32'h0, 1'b0);
    drive(3'd5, 1'b0, 256'h4, 256'h4, 32'd10, 8'h43, 1'b1, 32'h0, 1'b0);
    reset = 1'b1;
    valid_in = 1'b1; fmt_s = 3'd4; tag_in = 8'h77; c_val = 32'd1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid_out: got %b, required 0", valid_out); end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (n_out != n0) begin n_bad++; $display("FAIL rst_mid_flushed: got %0d outputs, required 0", n_out - n0); end
    @(posedge clk); #1;
    drive(3'd4, 1'b0, 256'h0000_0505, 256'h0000_0707, 32'hFFFF_FFFF, 8'h44, 1'b0, 32'd69, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== (k == 2)) begin
        n_bad++;
        $display("FAIL rst_mid_latency%0d: valid_out=%b, required %b", k + 1, valid_out, (k == 2));
      end
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL rst_mid_drain: %0d pending, required 0", sb.size()); end
    @(posedge clk); #1;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_out = ($urandom_range(0, 3) != 0);
        end
        ready_out = 1'b1;
      end
      begin
        logic [255:0] a, b;
        logic [31:0] c;
        for (int t = 0; t < 10000; t++) begin
          for (int i = 0; i < 8; i++) begin
            a[i*32 +: 32] = $urandom;
            b[i*32 +: 32] = $urandom;
          end
          case ($urandom_range(0, 3))
            0: c = 32'h7FFF_FFFF;
            1: c = 32'h8000_0000;
            default: c = $urandom;
          endcase
          drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b, c, 8'(t), 1'b1, 32'h0, 1'b0);
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
    join
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL random_drain: %0d pending, required 0", sb.size()); end
    $display("test_random done");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
